// File: rtl/axis_ifmaps_pack_fifo.sv
// axis_ifmaps_pack_fifo
//   Packs AXI-Stream beats of ELEM_WIDTH-bit ifmap elements into MAC-wide
//   entries (ELEM_WIDTH*MAC_NUM bits). Each entry is stored in a
//   FIFO_DEPTH-entry FIFO and handed to the MAC array with valid/ready.
//   The channel count C is taken per entry from input_channel_size on the
//   entry's first beat (0 or >MAC_NUM means MAC_NUM). Lanes >= C read as 0.
//   An entry becomes visible only once its last beat has been accepted.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               drop the partial entry and every stored entry
//   input_channel_size  channels per entry (sampled on first beat)
//   s_axis_tdata/tvalid/tready   input stream, EPB elements per beat
//   m_ifmaps/m_valid/m_ready     head entry towards the MAC array
//   fifo_level/fifo_empty/fifo_full  committed-entry status
//
// Optional feature: define IFMAPS_PACK_TLAST_CHK_EN to add s_axis_tlast
//   (early entry close) and frame_err (1-cycle pulse when tlast disagrees
//   with the beat count). Without it, framing is purely count-based.

// One lane of storage: FIFO_DEPTH elements, written by slot pointer.
module axis_ifmaps_pack_lane #(
  parameter int EW    = 5,
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic          i_clr,
  input  logic [PW-1:0] i_wptr,
  input  logic [EW-1:0] i_din,
  input  logic [PW-1:0] i_rptr,
  output logic [EW-1:0] o_dout
);
  logic [DEPTH-1:0][EW-1:0] r_mem;

  // The first beat of an entry clears lanes it does not write, so an
  // entry never inherits data from the previous occupant of its slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_mem <= '0;
    else if (i_we)  r_mem[i_wptr] <= i_din;
    else if (i_clr) r_mem[i_wptr] <= '0;
  end

  assign o_dout = r_mem[i_rptr];
endmodule

module axis_ifmaps_pack_fifo #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int ELEM_WIDTH           = 5,
  parameter int MAC_NUM              = 256,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic [11:0]                      input_channel_size,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  output logic [ELEM_WIDTH*MAC_NUM-1:0]    m_ifmaps,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic                             fifo_empty,
  output logic                             fifo_full
`ifdef IFMAPS_PACK_TLAST_CHK_EN
  ,
  input  logic                             s_axis_tlast,
  output logic                             frame_err
`endif
);
  localparam int TW  = C_S_AXIS_TDATA_WIDTH;
  localparam int EW  = ELEM_WIDTH;
  localparam int EPB = TW / EW;
  localparam int NB  = (MAC_NUM + EPB - 1) / EPB;
  localparam int BW  = $clog2(NB + 1);
  localparam int CW  = $clog2(MAC_NUM + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = PW + 1;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t          r_state, w_nstate;
  logic [BW-1:0]   r_beat, r_nb, w_nb, w_nb_in;
  logic [CW-1:0]   r_c, w_c, w_c_in;
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic            w_first, w_last, w_tlast, w_tready;
  logic            w_acc, w_pop, w_commit;

`ifdef IFMAPS_PACK_TLAST_CHK_EN
  assign w_tlast = s_axis_tlast;
`else
  assign w_tlast = 1'b0;
`endif

  // Effective channel count and beats-per-entry for an entry starting now.
  always_comb begin
    if (input_channel_size == 12'd0 || input_channel_size > 12'(MAC_NUM))
      w_c_in = CW'(MAC_NUM);
    else
      w_c_in = input_channel_size[CW-1:0];
    w_nb_in = BW'((int'(w_c_in) + EPB - 1) / EPB);
  end

  // Handshakes; flush overrides both sides.
  assign w_tready = (r_level < LW'(FIFO_DEPTH));
  assign w_acc    = s_axis_tvalid & w_tready & ~flush;
  assign w_pop    = (r_level != '0) & m_ready & ~flush;
  assign w_commit = w_acc & (w_last | w_tlast);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nstate;
  end

  // FSM: next state
  always_comb begin
    w_nstate = r_state;
    if (flush)         w_nstate = S_IDLE;
    else if (w_commit) w_nstate = S_IDLE;
    else if (w_acc)    w_nstate = S_FILL;
  end

  // FSM: outputs. In IDLE the live channel count is used; afterwards the
  // latched one, so mid-entry changes of input_channel_size are ignored.
  always_comb begin
    w_first = (r_state == S_IDLE);
    w_c     = w_first ? w_c_in  : r_c;
    w_nb    = w_first ? w_nb_in : r_nb;
    w_last  = (r_beat == w_nb - BW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat   <= '0;
      r_nb     <= '0;
      r_c      <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_beat   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_acc) begin
        if (w_first) begin
          r_c  <= w_c_in;
          r_nb <= w_nb_in;
        end
        if (w_commit) begin
          r_beat   <= '0;
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end else begin
          r_beat   <= r_beat + BW'(1);
        end
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_commit, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

`ifdef IFMAPS_PACK_TLAST_CHK_EN
  logic r_frame_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_frame_err <= 1'b0;
    else        r_frame_err <= w_acc & (w_tlast ^ w_last);
  end
  assign frame_err = r_frame_err;
`endif

  // Lane i always lives in beat i/EPB at element slot i%EPB of that beat.
  for (genvar i = 0; i < MAC_NUM; i++) begin : g_lane
    localparam int LB = i / EPB;
    localparam int LO = i % EPB;
    logic w_we, w_clr;
    assign w_we  = w_acc & (r_beat == BW'(LB)) & (CW'(i) < w_c);
    assign w_clr = w_acc & w_first;
    axis_ifmaps_pack_lane #(.EW(EW), .DEPTH(FIFO_DEPTH), .PW(PW)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_we   (w_we),
      .i_clr  (w_clr),
      .i_wptr (r_wr_ptr),
      .i_din  (s_axis_tdata[LO*EW +: EW]),
      .i_rptr (r_rd_ptr),
      .o_dout (m_ifmaps[i*EW +: EW])
    );
  end

  // Beat bits above EPB*ELEM_WIDTH carry no element.
  if (TW > EPB * EW) begin : g_hi
    logic w_unused_hi;
    assign w_unused_hi = ^s_axis_tdata[TW-1:EPB*EW];
  end

  assign s_axis_tready = w_tready;
  assign m_valid       = (r_level != '0);
  assign fifo_level    = r_level;
  assign fifo_empty    = (r_level == '0);
  assign fifo_full     = (r_level == LW'(FIFO_DEPTH));
endmodule

// File: tb/tb_axis_ifmaps_pack_fifo.sv
// Randomized bench for axis_ifmaps_pack_fifo: a queue-of-entries reference
// model is stepped every clock and compared against all outputs.
module tb_axis_ifmaps_pack_fifo;
  localparam int TW    = 32;
  localparam int EW    = 5;
  localparam int MAC   = 256;
  localparam int DEPTH = 4;
  localparam int EPB   = TW / EW;
  localparam int MW    = EW * MAC;

  logic          clk = 1'b0;
  logic          rst_n, flush, tvalid, tlast, mrdy;
  logic [11:0]   csize;
  logic [TW-1:0] tdata;
  logic          tready, m_valid, fifo_empty, fifo_full;
  logic [MW-1:0] m_ifmaps;
  logic [$clog2(DEPTH):0] fifo_level;
`ifdef IFMAPS_PACK_TLAST_CHK_EN
  logic          frame_err;
`endif

  always #5 clk = ~clk;

  axis_ifmaps_pack_fifo #(.C_S_AXIS_TDATA_WIDTH(TW), .ELEM_WIDTH(EW),
                          .MAC_NUM(MAC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .input_channel_size(csize),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .m_ifmaps(m_ifmaps), .m_valid(m_valid), .m_ready(mrdy),
    .fifo_level(fifo_level), .fifo_empty(fifo_empty), .fifo_full(fifo_full)
`ifdef IFMAPS_PACK_TLAST_CHK_EN
    , .s_axis_tlast(tlast), .frame_err(frame_err)
`endif
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: committed entries as full images, plus the entry
  // under construction.
  logic [MW-1:0] q[$];
  logic [MW-1:0] part;
  int  pbeat = 0, pc = 0, pnb = 0;
  bit  m_acc = 0, exp_ferr = 0, mr_fix = 0;

  function automatic int clampc(int s);
    return (s == 0 || s > MAC) ? MAC : s;
  endfunction

  task automatic compare();
    chk("tready", tready, q.size() < DEPTH);
    chk("m_valid", m_valid, q.size() != 0);
    chk("level", fifo_level, q.size());
    chk("empty", fifo_empty, q.size() == 0);
    chk("full", fifo_full, q.size() == DEPTH);
`ifdef IFMAPS_PACK_TLAST_CHK_EN
    chk("frame_err", frame_err, exp_ferr);
`endif
    if (q.size() != 0)
      for (int i = 0; i < MAC; i++)
        chk("ifmap", {32'(i), 32'(m_ifmaps[i*EW +: EW])}, {32'(i), 32'(q[0][i*EW +: EW])});
  endtask

  task automatic step();
    bit acc, pop, last, tl;
    @(posedge clk);
    acc = tvalid && (q.size() < DEPTH) && !flush;
    pop = mrdy && (q.size() != 0) && !flush;
`ifdef IFMAPS_PACK_TLAST_CHK_EN
    tl = tlast;
`else
    tl = 1'b0;
`endif
    m_acc = acc;
    exp_ferr = 0;
    if (flush) begin
      q.delete();
      pbeat = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        if (pbeat == 0) begin
          pc = clampc(int'(csize));
          pnb = (pc + EPB - 1) / EPB;
          part = '0;
        end
        for (int e = 0; e < EPB; e++) begin
          int ln = pbeat * EPB + e;
          if (ln < pc) part[ln*EW +: EW] = tdata[e*EW +: EW];
        end
        pbeat++;
        last = (pbeat == pnb);
        exp_ferr = (tl != last);
        if (last || tl) begin
          q.push_back(part);
          pbeat = 0;
        end
      end
    end
    @(negedge clk);
    compare();
  endtask

  task automatic cyc(bit v, logic [TW-1:0] d, bit mr, bit fl);
    tvalid = v; tdata = d; mrdy = mr; flush = fl;
    step();
    flush = 1'b0;
  endtask

  // Push one entry of channel count c. pat=1: element = lane mod 32.
  // tl_at: beat index carrying tlast (-2 = last beat, -1 = never).
  task automatic push_entry(int c, bit pat, bit rnd, int tl_at);
    int pcl, nb, tries;
    logic [TW-1:0] d;
    pcl = clampc(c);
    nb = (pcl + EPB - 1) / EPB;
    if (tl_at == -2) tl_at = nb - 1;
    csize = 12'(c);
    for (int k = 0; k < nb; k++) begin
      d = $urandom;
      if (pat)
        for (int e = 0; e < EPB; e++) d[e*EW +: EW] = EW'((k * EPB + e) % 32);
      tlast = (k == tl_at);
      if (rnd && $urandom_range(3) == 0) cyc(0, d, 1'($urandom_range(1)), 0);
      tries = 0;
      do begin
        cyc(1, d, rnd ? 1'($urandom_range(1)) : mr_fix, 0);
        tries++;
      end while (!m_acc && tries < 200);
      if (!m_acc) begin
        chk("accept_timeout", 0, 1);
        break;
      end
      csize = 12'($urandom);  // must be ignored until the next entry
      if (k == tl_at) break;
    end
    tvalid = 0;
    tlast = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cyc(0, '0, 1, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; flush = 0; tvalid = 0; tlast = 0; mrdy = 0; csize = '0; tdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_tready", tready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    for (int i = 0; i < MAC; i += 37) chk("rst_lane", m_ifmaps[i*EW +: EW], 0);
    rst_n = 1;
    @(negedge clk);

    // Full-width entry, 43 beats, lane-index pattern.
    mr_fix = 0;
    push_entry(256, 1, 0, -2);
    chk("t1_level", fifo_level, 1);
    chk("t1_lane255", m_ifmaps[255*EW +: EW], 255 % 32);
    drain();

    // Short entry, then C=0 clamped to full width.
    push_entry(10, 0, 0, -2);
    chk("t2_lane10", m_ifmaps[10*EW +: EW], 0);
    drain();
    push_entry(0, 0, 0, -2);
    drain();

    // Fill to full, hold the fifth beat, then pop to let it in.
    mr_fix = 0;
    for (int n = 0; n < 4; n++) push_entry(6, 0, 0, -2);
    chk("t3_full", fifo_full, 1);
    begin
      logic [TW-1:0] d5;
      d5 = $urandom;
      csize = 12'd6;
      tlast = 1;
      cyc(1, d5, 0, 0);
      cyc(1, d5, 0, 0);
      chk("t3_tready", tready, 0);
      cyc(1, d5, 1, 0);
      cyc(1, d5, 0, 0);
      chk("t3_level", fifo_level, 4);
      tvalid = 0; tlast = 0;
    end
    drain();

    // Level 2 with simultaneous commit and pop, across pointer wrap.
    mr_fix = 0;
    push_entry(6, 0, 0, -2);
    push_entry(6, 0, 0, -2);
    mr_fix = 1;
    for (int n = 0; n < 9; n++) begin
      push_entry(6, 0, 0, -2);
      chk("t4_level", fifo_level, 2);
    end
    mr_fix = 0;
    drain();

    // Flush mid-entry with three entries stored.
    for (int n = 0; n < 3; n++) push_entry(6, 0, 0, -2);
    csize = 12'd256;
    for (int k = 0; k < 20; k++) cyc(1, $urandom, 0, 0);
    cyc(1, $urandom, 1, 1);
    chk("t5_level", fifo_level, 0);
    chk("t5_m_valid", m_valid, 0);
    push_entry(6, 0, 0, -2);
    chk("t5_after", fifo_level, 1);
    drain();

`ifdef IFMAPS_PACK_TLAST_CHK_EN
    // Early tlast on the third of five beats, then a missing tlast.
    push_entry(30, 0, 0, 2);
    chk("t6_ferr_early", frame_err, 1);
    chk("t6_lane18", m_ifmaps[18*EW +: EW], 0);
    cyc(0, '0, 0, 0);
    chk("t6_ferr_pulse", frame_err, 0);
    push_entry(30, 0, 0, -1);
    chk("t6_ferr_late", frame_err, 1);
    drain();
`endif

    // Random traffic: channel counts, gaps, back-pressure, rare flushes.
    for (int n = 0; n < 150; n++) begin
      int c, r, tl;
      r = $urandom_range(9);
      c = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(4095)) : int'($urandom_range(MAC, 1));
`ifdef IFMAPS_PACK_TLAST_CHK_EN
      tl = ($urandom_range(5) == 0) ? int'($urandom_range(45)) : -2;
`else
      tl = -2;
`endif
      push_entry(c, 0, 1, tl);
      if ($urandom_range(19) == 0) cyc(1'($urandom_range(1)), $urandom, 1'($urandom_range(1)), 1);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
